cache_miss_arbiter: RTL and testbench
=====================================

# cache_miss_arbiter

Two-port miss arbiter between the I-cache and D-cache and the single shared cache fill FSM. It takes miss requests and addresses from both caches and grants one requester at a time using D-first round-robin. It issues a one-cycle `miss_detected` pulse with a block-aligned `miss_address` to the fill FSM, then routes the FSM's data and tag write strobes back to the granted cache only. It stalls each cache while that cache's miss is outstanding and flags fills that never complete.

## Interface
- `TIMEOUT`, default 64: maximum cycles in FILL before the fill is abandoned. Range 2..255.
- `OFFSET_W`, default 4: block-offset bits cleared in `miss_address` (16-byte blocks).
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_miss` in 1: I-cache miss request, level.
- `i_miss_addr` in 16: I-cache miss byte address.
- `d_miss` in 1: D-cache miss request, level.
- `d_miss_addr` in 16: D-cache miss byte address.
- `fsm_busy` in 1: fill FSM busy.
- `fsm_write_data` in 1: fill FSM data-array write strobe.
- `fsm_write_tag` in 1: fill FSM tag-array write strobe; marks the last beat.
- `miss_detected` out 1: registered one-cycle request pulse to the fill FSM.
- `miss_address` out 16: registered, granted address with bits [OFFSET_W-1:0] forced to 0.
- `i_write_data`, `i_write_tag` out 1 each: strobes routed to the I-cache.
- `d_write_data`, `d_write_tag` out 1 each: strobes routed to the D-cache.
- `i_stall`, `d_stall` out 1 each: per-cache pipeline stall.
- `owner` out 1: current or last grant (0 = I, 1 = D).
- `timeout_err` out 1: sticky; set when a fill is abandoned.

## Operation
- Reset values: state IDLE, `owner`=0, `last_grant`=I, timer=0, and every output 0.
- **IDLE**
  - Leaves IDLE only when `fsm_busy`=0 and at least one miss is asserted.
  - One miss asserted: that cache wins.
  - Both asserted: the cache opposite `last_grant` wins. After reset `last_grant`=I, so D wins the first tie.
  - On a grant: latch the winner into `owner` and `last_grant`, latch the aligned address, go to ISSUE.
- **ISSUE** (exactly 1 cycle)
  - `miss_detected`=1 and `miss_address` is valid.
  - Clear the timer and go to FILL.
- **FILL**
  - `owner` strobes = fsm strobes, combinationally. The other cache's strobes are 0.
  - The timer increments every cycle.
  - `fsm_write_tag`=1 → go to RELEASE.
  - Timer reaches TIMEOUT-1 with no tag write → set `timeout_err` and go to IDLE.
- **RELEASE** (exactly 1 cycle)
  - The owner's stall drops so the owner re-looks-up. Then go to IDLE.
- Outside FILL, all four routed strobes are 0, even if the fsm strobes are high.
- `i_stall` = `i_miss` & ~(state==RELEASE & `owner`==I). `d_stall` is the same with D.
  - A waiting loser stays stalled for the whole of the other cache's fill.
- The requester's `*_miss_addr` may change after the grant. The latched address is used.
- The requester dropping its miss mid-fill has no effect: the fill completes and the strobes still route to it.
- `timeout_err` is cleared only by `rst`.

## Timing
- Request seen in IDLE at edge N → `miss_detected` high for cycle N+1 → FILL from N+2.
- Minimum turnaround: `fsm_write_tag` high at cycle T → RELEASE at T+1 → IDLE at T+2 → the next grant can pulse `miss_detected` at T+3.
- Strobe routing is zero-latency (combinational AND with the state/`owner` decode).
- `miss_detected` is never high on two consecutive cycles.
- Asserting `rst` at any point, including mid-FILL, returns everything to reset values immediately (asynchronous). No strobes are routed afterwards.

## Test plan
- **Single I miss.** `i_miss`=1, addr 0x1237, FSM idle → `miss_detected` one cycle later with `miss_address`=0x1230, `owner`=0. Eight `fsm_write_data` pulses appear only on `i_write_data`. A tag pulse gives `i_write_tag`=1, then `i_stall`=0 for exactly one cycle.
- **Simultaneous misses after reset.** I addr 0x0040, D addr 0x8008 → D granted (`miss_address`=0x8000) and `i_stall` held high. After D's RELEASE, I is granted (0x0040) without I re-requesting.
- **Round-robin.** Both misses held continuously for four fills → grant order D, I, D, I.
- **Busy FSM.** `fsm_busy`=1 held in IDLE with `d_miss`=1 → no `miss_detected` until `fsm_busy` falls. The grant follows on the next edge.
- **Timeout.** TIMEOUT=64, FSM never asserts tag → `timeout_err`=1 exactly 64 cycles after entering FILL. State returns to IDLE and the error stays set until `rst`.
- **Reset mid-fill.** Assert `rst` 3 cycles into FILL → all outputs 0 in the same cycle. After release, a new D miss is accepted normally and `last_grant` is back to I.

Source files
------------

// File: rtl/cache_miss_arbiter.sv
// Two-port miss arbiter between the I-cache, the D-cache and one shared fill FSM.
// It grants with D-first round-robin, routes fill strobes to the winner and stalls waiting caches.
module cache_miss_arbiter #(
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned OFFSET_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic        fsm_busy,
  input  logic        fsm_write_data,
  input  logic        fsm_write_tag,
  output logic        miss_detected,
  output logic [15:0] miss_address,
  output logic        i_write_data,
  output logic        i_write_tag,
  output logic        d_write_data,
  output logic        d_write_tag,
  output logic        i_stall,
  output logic        d_stall,
  output logic        owner,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    FILL    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic        OWNER_I    = 1'b0;
  localparam logic        OWNER_D    = 1'b1;
  localparam logic [15:0] ALIGN_MASK = ~((16'd1 << OFFSET_W) - 16'd1);
  localparam logic [7:0]  TIMER_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        owner_nxt;
  logic [7:0]  timer, timer_nxt;
  logic [15:0] addr_nxt;
  logic        issue_nxt;
  logic        err_nxt;
  logic        grant_d;
  logic        in_fill;
  logic        in_release;

  // owner also serves as last_grant: a tie goes to the cache that did not win last time.
  assign grant_d = d_miss & (~i_miss | (owner == OWNER_I));

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    timer_nxt = timer;
    addr_nxt  = miss_address;
    issue_nxt = 1'b0;
    err_nxt   = timeout_err;
    case (state)
      IDLE: begin
        if (!fsm_busy && (i_miss || d_miss)) begin
          owner_nxt = grant_d;
          addr_nxt  = (grant_d ? d_miss_addr : i_miss_addr) & ALIGN_MASK;
          issue_nxt = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        timer_nxt = '0;
        state_nxt = FILL;
      end
      FILL: begin
        if (fsm_write_tag) begin
          state_nxt = RELEASE;
        end else if (timer == TIMER_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + 8'd1;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= OWNER_I;
      timer         <= '0;
      miss_address  <= '0;
      miss_detected <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_nxt;
      owner         <= owner_nxt;
      timer         <= timer_nxt;
      miss_address  <= addr_nxt;
      miss_detected <= issue_nxt;
      timeout_err   <= err_nxt;
    end
  end

  assign in_fill    = (state == FILL);
  assign in_release = (state == RELEASE);

  // Strobe routing is purely combinational so fill beats reach the cache with no added latency.
  assign i_write_data = in_fill & (owner == OWNER_I) & fsm_write_data;
  assign i_write_tag  = in_fill & (owner == OWNER_I) & fsm_write_tag;
  assign d_write_data = in_fill & (owner == OWNER_D) & fsm_write_data;
  assign d_write_tag  = in_fill & (owner == OWNER_D) & fsm_write_tag;

  assign i_stall = i_miss & ~(in_release & (owner == OWNER_I));
  assign d_stall = d_miss & ~(in_release & (owner == OWNER_D));

endmodule

// File: tb/tb_cache_miss_arbiter.sv
// Directed bench for cache_miss_arbiter: a cycle table for a single I-cache fill plus
// hand-written sequences for tie-breaking, round-robin, busy FSM, timeout and async reset.
module tb_cache_miss_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_miss, d_miss, fsm_busy, fsm_write_data, fsm_write_tag;
  logic [15:0] i_miss_addr, d_miss_addr;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        i_write_data, i_write_tag, d_write_data, d_write_tag;
  logic        i_stall, d_stall, owner, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cache_miss_arbiter #(.TIMEOUT(64), .OFFSET_W(4)) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .fsm_busy(fsm_busy), .fsm_write_data(fsm_write_data), .fsm_write_tag(fsm_write_tag),
    .miss_detected(miss_detected), .miss_address(miss_address),
    .i_write_data(i_write_data), .i_write_tag(i_write_tag),
    .d_write_data(d_write_data), .d_write_tag(d_write_tag),
    .i_stall(i_stall), .d_stall(d_stall), .owner(owner), .timeout_err(timeout_err)
  );

  typedef struct {
    logic        im;
    logic [15:0] ia;
    logic        dm;
    logic [15:0] da;
    logic        busy, wd, wt;
    logic        md;
    logic [15:0] ma;
    logic        own, iwd, iwt, dwd, dwt, ist, dst;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic im, input logic [15:0] ia, input logic dm,
                       input logic [15:0] da, input logic busy, input logic wd, input logic wt);
    i_miss = im; i_miss_addr = ia; d_miss = dm; d_miss_addr = da;
    fsm_busy = busy; fsm_write_data = wd; fsm_write_tag = wt;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_md"},   16'(miss_detected), 16'h0);
    check({tag, "_ma"},   miss_address,       16'h0);
    check({tag, "_own"},  16'(owner),         16'h0);
    check({tag, "_err"},  16'(timeout_err),   16'h0);
    check({tag, "_strb"}, 16'({i_write_data, i_write_tag, d_write_data, d_write_tag}), 16'h0);
    check({tag, "_stl"},  16'({i_stall, d_stall}), 16'h0);
  endtask

  task automatic do_reset();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  function automatic vec_t mk(input logic im, input logic [15:0] ia, input logic dm,
                              input logic [15:0] da, input logic busy, input logic wd,
                              input logic wt, input logic md, input logic [15:0] ma,
                              input logic iwd, input logic iwt, input logic ist, input logic dst);
    vec_t v;
    v.im = im; v.ia = ia; v.dm = dm; v.da = da; v.busy = busy; v.wd = wd; v.wt = wt;
    v.md = md; v.ma = ma; v.own = 1'b0; v.iwd = iwd; v.iwt = iwt;
    v.dwd = 1'b0; v.dwt = 1'b0; v.ist = ist; v.dst = dst;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_own;

    // Single I miss at 0x1237: the address changes after the grant and the D side
    // raises a miss during the fill; neither may disturb the I fill.
    vecs[0]  = mk(1, 16'h1237, 0, 16'h0000, 0, 0, 0,  0, 16'h0000, 0, 0, 1, 0); // IDLE
    vecs[1]  = mk(1, 16'hFFFF, 1, 16'hABCD, 1, 1, 1,  1, 16'h1230, 0, 0, 1, 1); // ISSUE
    for (int k = 2; k < 10; k++)
      vecs[k] = mk(1, 16'hFFFF, 1, 16'hABCD, 1, 1, 0, 0, 16'h1230, 1, 0, 1, 1); // FILL data
    vecs[10] = mk(1, 16'hFFFF, 1, 16'hABCD, 1, 0, 1,  0, 16'h1230, 0, 1, 1, 1); // FILL tag
    vecs[11] = mk(1, 16'hFFFF, 1, 16'hABCD, 1, 1, 1,  0, 16'h1230, 0, 0, 0, 1); // RELEASE
    vecs[12] = mk(1, 16'hFFFF, 1, 16'hABCD, 1, 1, 1,  0, 16'h1230, 0, 0, 1, 1); // IDLE, busy

    do_reset();
    check_all_zero("reset");

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].im, vecs[i].ia, vecs[i].dm, vecs[i].da,
            vecs[i].busy, vecs[i].wd, vecs[i].wt);
      #1;
      check($sformatf("v%0d_md", i),  16'(miss_detected), 16'(vecs[i].md));
      check($sformatf("v%0d_ma", i),  miss_address,       vecs[i].ma);
      check($sformatf("v%0d_own", i), 16'(owner),         16'(vecs[i].own));
      check($sformatf("v%0d_iwd", i), 16'(i_write_data),  16'(vecs[i].iwd));
      check($sformatf("v%0d_iwt", i), 16'(i_write_tag),   16'(vecs[i].iwt));
      check($sformatf("v%0d_dwd", i), 16'(d_write_data),  16'(vecs[i].dwd));
      check($sformatf("v%0d_dwt", i), 16'(d_write_tag),   16'(vecs[i].dwt));
      check($sformatf("v%0d_ist", i), 16'(i_stall),       16'(vecs[i].ist));
      check($sformatf("v%0d_dst", i), 16'(d_stall),       16'(vecs[i].dst));
      tick();
    end

    // Simultaneous misses after reset, held continuously: grants go D, I, D, I.
    do_reset();
    drive(1'b1, 16'h0040, 1'b1, 16'h8008, 1'b0, 1'b0, 1'b0);
    #1;
    check("rr_idle_md", 16'(miss_detected), 16'h0);
    for (int k = 0; k < 4; k++) begin
      exp_own = (k % 2 == 0);
      tick(); // ISSUE
      check($sformatf("rr%0d_md", k),  16'(miss_detected), 16'h1);
      check($sformatf("rr%0d_own", k), 16'(owner), 16'(exp_own));
      check($sformatf("rr%0d_ma", k),  miss_address, exp_own ? 16'h8000 : 16'h0040);
      check($sformatf("rr%0d_stl", k), 16'({i_stall, d_stall}), 16'h3);
      tick(); // FILL
      fsm_write_data = 1'b1;
      #1;
      check($sformatf("rr%0d_md2", k), 16'(miss_detected), 16'h0);
      check($sformatf("rr%0d_wd", k), 16'({i_write_data, d_write_data}),
            exp_own ? 16'h1 : 16'h2);
      tick();
      fsm_write_data = 1'b0;
      fsm_write_tag  = 1'b1;
      #1;
      check($sformatf("rr%0d_wt", k), 16'({i_write_tag, d_write_tag}),
            exp_own ? 16'h1 : 16'h2);
      tick(); // RELEASE, tag still high must not route
      check($sformatf("rr%0d_rel_stl", k), 16'({i_stall, d_stall}),
            exp_own ? 16'h2 : 16'h1);
      check($sformatf("rr%0d_rel_wt", k), 16'({i_write_tag, d_write_tag}), 16'h0);
      tick(); // IDLE
      fsm_write_tag = 1'b0;
      #1;
      check($sformatf("rr%0d_idle_stl", k), 16'({i_stall, d_stall}), 16'h3);
    end

    // Busy FSM holds off the grant; the grant follows on the edge after busy falls.
    do_reset();
    drive(1'b0, 16'h0000, 1'b1, 16'h2345, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("busy%0d_md", k), 16'(miss_detected), 16'h0);
    end
    fsm_busy = 1'b0;
    tick();
    check("busy_rel_md",  16'(miss_detected), 16'h1);
    check("busy_rel_ma",  miss_address, 16'h2340);
    check("busy_rel_own", 16'(owner), 16'h1);

    // Timeout: no tag write ever; error must appear exactly 64 cycles after FILL begins.
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    tick(); // FILL entered
    for (int c = 1; c < 64; c++) tick();
    check("to_pre_err", 16'(timeout_err), 16'h0);
    check("to_pre_dwd", 16'(d_write_data), 16'h1);
    tick();
    check("to_err",      16'(timeout_err), 16'h1);
    check("to_idle_dwd", 16'(d_write_data), 16'h0);
    d_miss = 1'b1;
    d_miss_addr = 16'h0105;
    tick(); // back in IDLE, so a new grant issues
    check("to_regrant_md", 16'(miss_detected), 16'h1);
    check("to_regrant_ma", miss_address, 16'h0100);
    check("to_sticky",     16'(timeout_err), 16'h1);

    // Reset mid-fill: requester drops its miss (fill continues), then async reset.
    tick(); // FILL, owner D
    d_miss = 1'b0;
    #1;
    check("drop_dwd", 16'(d_write_data), 16'h1);
    check("drop_dst", 16'(d_stall), 16'h0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    #2;
    rst = 1'b0;
    drive(1'b1, 16'h1111, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
    tick();
    check("postrst_md",  16'(miss_detected), 16'h1);
    check("postrst_own", 16'(owner), 16'h1);
    check("postrst_ma",  miss_address, 16'h2220);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
